channel_pole_sched: RTL
=======================

Name: channel_pole_sched

Overview:
- Fixed-point, clocked replacement for the behavioural multi-pole channel model.
- One sample strobe triggers a scheduler that walks all NPOLE complex pole/residue states through a single shared complex multiply-accumulate engine, one pole per cycle.
- The scheduler then emits the channel output sample.
- Also owns the coefficient register bank (host-configurable between samples) and the state-clear sequencing.

Parameters:
- NPOLE, 6, number of pole/residue pairs (conjugate pairs count as two).
- XW, 16, signed input sample width.
- CW, 18, signed coefficient width, format Q1.(CW-1).
- AW, 32, signed state/accumulator and output width.
- XSH, 0, left shift applied to x before gain multiply (input scaling).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- x_valid, in, 1, input sample valid.
- x_ready, out, 1, block can accept a sample.
- x_data, in, XW, signed input sample.
- y_valid, out, 1, one-cycle pulse, y_data valid.
- y_data, out, AW, signed channel output.
- cfg_we, in, 1, coefficient write request.
- cfg_ready, out, 1, write accepted this cycle when cfg_we=1.
- cfg_pole, in, $clog2(NPOLE), pole index.
- cfg_field, in, 3, 0=gain_r 1=gain_i 2=exp_r 3=exp_i 4=dc_gain (pole index ignored), 5-7 ignored.
- cfg_data, in, CW, signed coefficient.
- clr_state, in, 1, request to zero all pole states.
- busy, out, 1, high when not IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state IDLE; all ac_r/ac_i = 0; all coefficients and dc_gain = 0; y_data = 0; y_valid = 0; busy = 0; clear-pending = 0.
- x_ready = (state==IDLE) & ~clr_state.
- cfg_ready = (state==IDLE).
- FSM IDLE: on x_valid & x_ready, latch xs = x_data <<< XSH (sign-extended to AW), clear sum, set p=0, go to RUN. Otherwise, a cfg write with cfg_ready updates the addressed register next edge. A write with cfg_pole >= NPOLE or cfg_field >= 5 is accepted and discarded.
- FSM RUN, one cycle per pole p:
  - sum += ac_r[p] (pre-update value; one-sample delay, equal to nonblocking update semantics).
  - ac_r[p] <= sat(((er*ar - ei*ai) >>> (CW-1)) + ((gr*xs) >>> (CW-1))).
  - ac_i[p] <= sat(((ei*ar + er*ai) >>> (CW-1)) + ((gi*xs) >>> (CW-1))).
  - Products are full width, shifts are arithmetic (floor, no rounding), and sat() clamps to [-2^(AW-1), 2^(AW-1)-1].
  - After p = NPOLE-1, go to OUT.
- FSM OUT: y_data <= sat(sum + ((dc_gain*xs) >>> (CW-1))); y_valid = 1 for this cycle only; go to IDLE.
  - The internal sum is AW+$clog2(NPOLE+1) bits and saturates only at the output.
- Timing: latency from acceptance edge T is y_valid at cycle T+NPOLE+1. Max throughput is one sample per NPOLE+2 cycles. busy = 1 in RUN and OUT.
- clr_state in IDLE: all ac_r/ac_i zero at the next edge. clr_state has priority over a simultaneous x_valid: the sample is not accepted because x_ready is low.
- clr_state in RUN/OUT: sets clear-pending. The current sample completes with normal arithmetic. The clear is applied on the OUT→IDLE edge, so states are zero on IDLE entry. clear-pending then resets.
- Coefficients never change during RUN/OUT (cfg_ready = 0); the host holds cfg_we until accepted.
- rst_n low in any state: reset values at the next edge; any in-flight sample is dropped with no y_valid.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with x_valid = 1 → y_valid = 0, y_data = 0, x_ready = 0 during reset, busy = 0, x_ready = 1 after release.
- Real pole impulse (NPOLE = 6, only pole 0 set: exp_r = 65536 (0.5), gain_r = 65536, others 0): x = 1000, 0, 0 → y = 0, 500, 250. Each y_valid arrives exactly 7 cycles after the acceptance edge.
- Complex pair (pole0 er = 0, ei = 65536, gr = 65536; pole1 conjugate): x = 1000, then zeros → ac_r0/ac_r1 = 500, then 0, then -125. Outputs y = 0, 1000, 0, -250.
- Saturation (XSH = 15, er = 131071, gr = 131071, x = 32767 held) → ac_r0 reaches 2^31-1 and stays there, no wrap. y_data clamps to 2147483647.
- Config/handshake: cfg_we during RUN → cfg_ready = 0, coefficient unchanged, written on IDLE return. x_valid held high while busy → second sample accepted exactly NPOLE+2 cycles after the first.
- Clear mid-run: pulse clr_state in RUN cycle 2 → current y unaffected, all states 0 in IDLE. clr_state and x_valid together in IDLE → sample not accepted, states cleared.

Source files
------------

// File: rtl/channel_pole_sched.sv
// channel_pole_sched: fixed-point multi-pole channel model. A single shared
// complex MAC walks the NPOLE pole/residue states, one pole per cycle, then
// emits y. Also holds the host coefficient bank and the state-clear sequencing.
module channel_pole_sched #(
  parameter int NPOLE = 6,
  parameter int XW    = 16,
  parameter int CW    = 18,
  parameter int AW    = 32,
  parameter int XSH   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [XW-1:0]              x_data,
  output logic                       y_valid,
  output logic [AW-1:0]              y_data,
  input  logic                       cfg_we,
  output logic                       cfg_ready,
  input  logic [$clog2(NPOLE)-1:0]   cfg_pole,
  input  logic [2:0]                 cfg_field,
  input  logic [CW-1:0]              cfg_data,
  input  logic                       clr_state,
  output logic                       busy
);

  localparam int PIW = (NPOLE > 1) ? $clog2(NPOLE) : 1;
  localparam int SW  = AW + $clog2(NPOLE + 1);
  localparam int PW  = CW + AW + 3;
  localparam int SH  = CW - 1;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                 state_q, state_d;
  logic [PIW-1:0]         p_q, p_d;
  logic signed [AW-1:0]   xs_q, xs_d;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic signed [AW-1:0]   ac_r_q [NPOLE];
  logic signed [AW-1:0]   ac_r_d [NPOLE];
  logic signed [AW-1:0]   ac_i_q [NPOLE];
  logic signed [AW-1:0]   ac_i_d [NPOLE];
  logic signed [CW-1:0]   gr_q [NPOLE];
  logic signed [CW-1:0]   gr_d [NPOLE];
  logic signed [CW-1:0]   gi_q [NPOLE];
  logic signed [CW-1:0]   gi_d [NPOLE];
  logic signed [CW-1:0]   er_q [NPOLE];
  logic signed [CW-1:0]   er_d [NPOLE];
  logic signed [CW-1:0]   ei_q [NPOLE];
  logic signed [CW-1:0]   ei_d [NPOLE];
  logic signed [CW-1:0]   dc_q, dc_d;
  logic signed [AW-1:0]   y_data_q, y_data_d;
  logic                   y_valid_q, y_valid_d;
  logic                   pend_q, pend_d;

  logic signed [AW-1:0]   xs_in;
  logic signed [CW-1:0]   cfg_s;
  logic signed [PW-1:0]   ar_w, ai_w, er_w, ei_w, gr_w, gi_w, xs_w;
  logic signed [PW-1:0]   mac_re, mac_im, y_wide;

  // Clamp a wide signed value into the AW-bit signed range.
  function automatic logic signed [AW-1:0] sat_aw(input logic signed [PW-1:0] v);
    if ((&v[PW-1:AW-1]) || !(|v[PW-1:AW-1])) return v[AW-1:0];
    else return {v[PW-1], {(AW-1){~v[PW-1]}}};
  endfunction

  assign xs_in     = AW'(signed'(x_data)) <<< XSH;
  assign cfg_s     = signed'(cfg_data);
  assign x_ready   = rst_n & (state_q == IDLE) & ~clr_state;
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign y_valid   = y_valid_q;
  assign y_data    = y_data_q;

  // Shared complex MAC for the current pole, plus the output dc term.
  always_comb begin
    ar_w   = PW'(ac_r_q[p_q]);
    ai_w   = PW'(ac_i_q[p_q]);
    er_w   = PW'(er_q[p_q]);
    ei_w   = PW'(ei_q[p_q]);
    gr_w   = PW'(gr_q[p_q]);
    gi_w   = PW'(gi_q[p_q]);
    xs_w   = PW'(xs_q);
    mac_re = ((er_w * ar_w - ei_w * ai_w) >>> SH) + ((gr_w * xs_w) >>> SH);
    mac_im = ((ei_w * ar_w + er_w * ai_w) >>> SH) + ((gi_w * xs_w) >>> SH);
    y_wide = PW'(sum_q) + ((PW'(dc_q) * xs_w) >>> SH);
  end

  // Next-state logic for the scheduler, state bank and coefficient bank.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    xs_d      = xs_q;
    sum_d     = sum_q;
    ac_r_d    = ac_r_q;
    ac_i_d    = ac_i_q;
    gr_d      = gr_q;
    gi_d      = gi_q;
    er_d      = er_q;
    ei_d      = ei_q;
    dc_d      = dc_q;
    y_data_d  = y_data_q;
    y_valid_d = 1'b0;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        if (clr_state) begin
          for (int unsigned i = 0; i < NPOLE; i++) begin
            ac_r_d[i] = '0;
            ac_i_d[i] = '0;
          end
        end else if (x_valid && x_ready) begin
          xs_d    = xs_in;
          sum_d   = '0;
          p_d     = '0;
          state_d = RUN;
        end
        if (cfg_we) begin
          if (cfg_field == 3'd4) dc_d = cfg_s;
          else if (int'(cfg_pole) < NPOLE) begin
            case (cfg_field)
              3'd0:    gr_d[cfg_pole] = cfg_s;
              3'd1:    gi_d[cfg_pole] = cfg_s;
              3'd2:    er_d[cfg_pole] = cfg_s;
              3'd3:    ei_d[cfg_pole] = cfg_s;
              default: ;
            endcase
          end
        end
      end
      RUN: begin
        sum_d       = sum_q + SW'(ac_r_q[p_q]);
        ac_r_d[p_q] = sat_aw(mac_re);
        ac_i_d[p_q] = sat_aw(mac_im);
        if (clr_state) pend_d = 1'b1;
        if (p_q == PIW'(NPOLE - 1)) state_d = OUT;
        else p_d = p_q + PIW'(1);
      end
      OUT: begin
        y_data_d  = sat_aw(y_wide);
        y_valid_d = 1'b1;
        state_d   = IDLE;
        // A clear requested while busy lands on the OUT->IDLE edge.
        if (pend_q || clr_state) begin
          for (int unsigned i = 0; i < NPOLE; i++) begin
            ac_r_d[i] = '0;
            ac_i_d[i] = '0;
          end
        end
        pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register everything; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      xs_q      <= '0;
      sum_q     <= '0;
      dc_q      <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      pend_q    <= 1'b0;
      for (int unsigned i = 0; i < NPOLE; i++) begin
        ac_r_q[i] <= '0;
        ac_i_q[i] <= '0;
        gr_q[i]   <= '0;
        gi_q[i]   <= '0;
        er_q[i]   <= '0;
        ei_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      xs_q      <= xs_d;
      sum_q     <= sum_d;
      dc_q      <= dc_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      pend_q    <= pend_d;
      ac_r_q    <= ac_r_d;
      ac_i_q    <= ac_i_d;
      gr_q      <= gr_d;
      gi_q      <= gi_d;
      er_q      <= er_d;
      ei_q      <= ei_d;
    end
  end

endmodule
